sfifo_gen: RTL
==============

SFIFO_GEN -- requirements
Module: sfifo_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter ADDR_W, default 4, log2 of depth; DEPTH = 2**ADDR_W (ADDR_W >= 1).
REQ-003 SHALL have parameter AF_THRESH, default 14, almost-full level (1..DEPTH).
REQ-004 SHALL have parameter AE_THRESH, default 2, almost-empty level (0..DEPTH-1).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port w_en  input  1  write request.
REQ-008 SHALL have port din  input  DATA_W  write data.
REQ-009 SHALL have port r_en  input  1  read request.
REQ-010 SHALL have port dout  output  DATA_W  registered read data.
REQ-011 SHALL have port dout_vld  output  1  one-cycle strobe, dout carries newly read word.
REQ-012 SHALL have port count  output  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have ports overflow, underflow  output  1 each  one-cycle error strobes.

Function
REQ-015 Write SHALL be accepted iff w_en=1 and full=1'b0 at the clock edge; accepted word stored at wptr, wptr incremented.
REQ-016 Read SHALL be accepted iff r_en=1 and empty=1'b0 at the clock edge; mem[rptr] loaded into dout at that edge, rptr incremented.
REQ-017 Read latency: dout and dout_vld=1 valid in the cycle immediately after the accepting edge; dout_vld=0 otherwise.
REQ-018 dout SHALL hold its last value when no read is accepted.
REQ-019 wptr and rptr SHALL be ADDR_W bits, wrapping DEPTH-1 -> 0 with no extra logic.
REQ-020 count SHALL be +1 on write-only, -1 on read-only, unchanged on both accepted or neither.
REQ-021 Simultaneous accepted read and write SHALL be legal at any occupancy 1..DEPTH-1; write data of that cycle SHALL never be returned by that cycle's read.
REQ-022 When full, w_en with r_en: read accepted, write rejected, overflow=1 next cycle; when empty, r_en with w_en: write accepted, read rejected, underflow=1 next cycle.
REQ-023 full = (count==DEPTH); empty = (count==0); almost_full = (count>=AF_THRESH); almost_empty = (count<=AE_THRESH); all decoded from registered count only, no combinational path from inputs.
REQ-024 overflow SHALL pulse 1 cycle after each edge with w_en=1 and full=1; underflow SHALL pulse 1 cycle after each edge with r_en=1 and empty=1.
REQ-025 Rejected requests SHALL not change pointers, count, memory or dout.

Reset
REQ-026 rst=1 at an edge SHALL dominate w_en/r_en, including mid-burst.
REQ-027 Reset values: wptr=0, rptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0 (1 if AF_THRESH would be 0, disallowed), dout=0, dout_vld=0, overflow=0, underflow=0.
REQ-028 Memory array SHALL not be reset; contents after reset are unreadable until rewritten.

Verification (DATA_W=8, ADDR_W=4 unless noted)
REQ-029 Reset, write 0x75..0x77, read 3 -> dout_vld 1 cycle after each read, dout 0x75,0x76,0x77; empty=1 after third read, count=0.
REQ-030 Write 16 words 0x00..0x0F -> almost_full=1 when count=14, full=1 at 16; 17th write -> overflow pulse, count stays 16; read all -> 0x00..0x0F in order.
REQ-031 Empty FIFO, r_en=1 -> underflow=1 for one cycle, dout_vld=0, dout unchanged.
REQ-032 Fill to 8, then 40 cycles continuous w_en+r_en with incrementing data wrapping 0xFF->0x00 -> count stays 8, pointers wrap twice, output sequence gap-free.
REQ-033 Full FIFO, w_en+r_en same edge -> one word read, overflow=1, count=15; empty FIFO, w_en+r_en -> word written, underflow=1, count=1.
REQ-034 rst=1 asserted with count=9 and w_en=r_en=1 -> next cycle all outputs at REQ-027 values; random-stimulus run vs. reference queue model, DATA_W=12, ADDR_W=3, AF_THRESH=6, AE_THRESH=1, zero mismatches.

Source files
------------

// File: rtl/sfifo_gen.sv
// Single-clock synchronous FIFO with registered read data, occupancy count,
// full/empty/almost flags decoded from the count register, and error strobes.
module sfifo_gen #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 4,
   parameter int AF_THRESH = 14,
   parameter int AE_THRESH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              w_en,
   input  logic [DATA_W-1:0] din,
   input  logic              r_en,
   output logic [DATA_W-1:0] dout,
   output logic              dout_vld,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow,
   output logic              underflow
);

   localparam int              DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_THRESH);
   localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_THRESH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dout_vld_q;
   logic              ovf_q;
   logic              unf_q;
   logic              wr_acc;
   logic              rd_acc;

   // Flags depend only on the registered count, never on this cycle's requests.
   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);

   assign wr_acc = w_en & ~full;
   assign rd_acc = r_en & ~empty;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      dout_d  = dout_q;
      if (wr_acc) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (rd_acc) begin
         rptr_d = rptr_q + 1'b1;
         dout_d = mem_q[rptr_q];
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage is deliberately left unreset; the count guards stale entries.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem_q[wptr_q] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         dout_q     <= dout_d;
         dout_vld_q <= rd_acc;
         ovf_q      <= w_en & full;
         unf_q      <= r_en & empty;
      end
   end

   assign dout      = dout_q;
   assign dout_vld  = dout_vld_q;
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule
